peak_finder: RTL and testbench
==============================

// Module: peak_finder
// PURPOSE
// Sits directly downstream of the trapezoidal shaping filter and consumes its signed output, one sample per clk.
// Detects threshold crossings and tracks the flat-top maximum of each shaped pulse.
// Emits one event per pulse: amplitude, timestamp and quality flags (pile-up, over-length).
// PARAMETERS
// DATA_W   20   width of signed input sample (filter output width)
// TS_W     16   width of free-running timestamp counter
// HYST     8    drop below running max (LSB) that arms double-peak detection
// MAX_LEN  64   max samples in RISE before forced event (over-length)
// HOLDOFF  16   dead-time samples after each event
// PORTS
// clk          in   1       single clock, all logic on rising edge
// reset        in   1       synchronous, active-high
// input_data   in   DATA_W  signed shaped sample, new value every clk
// thr          in   DATA_W  signed trigger threshold, sampled every clk, must be >= 0
// peak_amp     out  DATA_W  signed max of the pulse
// peak_time    out  TS_W    timestamp of first sample equal to max
// peak_valid   out  1       one-cycle strobe, event fields valid
// pile_up      out  1       event flag: double peak or retrigger in holdoff
// over_len     out  1       event flag: pulse forced out by MAX_LEN
// busy         out  1       high in RISE or HOLD
// BEHAVIOUR
// - reset=1 at edge: state IDLE, ts counter 0, all outputs 0, internal max/len/flags 0; wins over any event, incl. mid-pulse (pulse dropped, no strobe).
// - ts: increments every clk, wraps 2^TS_W-1 -> 0; value at edge n tags sample n.
// - All compares are signed. "above" means input_data > thr (strict).
// - IDLE: if above -> RISE; max<=input_data, tmax<=ts, len<=1, fell<=0, dbl<=0.
// - RISE, per sample:
//   - input_data > max: max<=input_data, tmax<=ts. Ties keep earlier tmax.
//     If fell=1 this rise is a double peak: dbl<=1.
//   - input_data < max-HYST (signed, DATA_W+1 wide, no wrap): fell<=1.
//   - not above: emit; state HOLD.
//   - else len==MAX_LEN-1: emit with over_len=1; state HOLD.
//   - else len<=len+1.
// - emit: at that edge peak_amp<=max, peak_time<=tmax, pile_up<=dbl|pend, over_len as above, peak_valid<=1.
//   Strobe is visible the cycle after the falling sample is sampled. pend<=0.
// - peak_valid (and flags) return to 0 on next edge. Fields peak_amp/peak_time hold until next emit.
// - HOLD: counter counts HOLDOFF samples.
//   - Any above sample during HOLD sets pend<=1.
//   - At expiry: above -> RISE (new pulse, pend carried into its event); else -> IDLE with pend<=0.
// - busy = (state!=IDLE), registered with state.
// - Peak spanning ts wrap: tmax is raw counter value, no correction.
// - Input stuck above thr: events every MAX_LEN+HOLDOFF samples, each over_len=1.
// TESTING
// - reset 3 clk, input 0, thr 100 -> all outputs 0, busy 0, ts counts from 0.
// - single pulse 0,50,200,500,500,300,80,0 (thr 100, ts of first 0 = 10) -> one strobe, amp 500, time 13, flags 0, busy held for HOLDOFF.
// - double peak 200,600,400,580,650,90 -> amp 650, pile_up=1.
// - retrigger 4 samples after event with 300 -> next event pile_up=1; later isolated pulse pile_up=0.
// - constant 1000 for 200 clk -> strobes every MAX_LEN+HOLDOFF=80 clk, amp 1000, over_len=1.
// - reset asserted mid-RISE, then 0 input -> no strobe, state IDLE, ts 0.
// - max sample at ts 65535, fall at ts 1 -> peak_time 65535.

Source files
------------

// File: rtl/peak_finder.sv
// Peak finder for the trapezoidal shaper output: threshold trigger, flat-top
// maximum tracking, and one event per pulse with pile-up / over-length flags.
module peak_finder #(
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned HYST    = 8,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned HOLDOFF = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] thr,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]          peak_time,
  output logic                     peak_valid,
  output logic                     pile_up,
  output logic                     over_len,
  output logic                     busy
);

  localparam int unsigned LEN_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned HCNT_W = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [TS_W-1:0]            ts_q, tmax_q, tmax_d, time_d;
  logic signed [DATA_W-1:0]   max_q, max_d, amp_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [HCNT_W-1:0]          hcnt_q, hcnt_d;
  logic                       fell_q, fell_d, dbl_q, dbl_d, pend_q, pend_d;
  logic                       valid_d, pile_d, ovl_d;
  logic                       above_c, drop_c, start_c, emit_c, force_c;
  logic signed [DATA_W:0]     floor_c;

  // One extra bit so max-HYST cannot wrap near the negative rail
  assign floor_c = $signed({max_q[DATA_W-1], max_q}) - $signed((DATA_W+1)'(HYST));
  assign drop_c  = $signed({input_data[DATA_W-1], input_data}) < floor_c;
  assign above_c = input_data > thr;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    tmax_d  = tmax_q;
    len_d   = len_q;
    hcnt_d  = hcnt_q;
    fell_d  = fell_q;
    dbl_d   = dbl_q;
    pend_d  = pend_q;
    amp_d   = peak_amp;
    time_d  = peak_time;
    valid_d = 1'b0;
    pile_d  = 1'b0;
    ovl_d   = 1'b0;
    start_c = 1'b0;
    emit_c  = 1'b0;
    force_c = 1'b0;

    case (state_q)
      IDLE: start_c = above_c;
      RISE: begin
        if (input_data > max_q) begin
          max_d  = input_data;
          tmax_d = ts_q;
          if (fell_q) dbl_d = 1'b1;
        end
        if (drop_c) fell_d = 1'b1;
        if (!above_c) begin
          emit_c = 1'b1;
        end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
          emit_c  = 1'b1;
          force_c = 1'b1;
        end else begin
          len_d = len_q + LEN_W'(1);
        end
      end
      HOLD: begin
        // Dead time first, then the next sample decides restart vs idle
        if (hcnt_q == HCNT_W'(HOLDOFF)) begin
          if (above_c) begin
            start_c = 1'b1;
          end else begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
          if (above_c) pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_c) begin
      state_d = RISE;
      max_d   = input_data;
      tmax_d  = ts_q;
      len_d   = LEN_W'(1);
      fell_d  = 1'b0;
      dbl_d   = 1'b0;
    end

    if (emit_c) begin
      state_d = HOLD;
      amp_d   = max_q;
      time_d  = tmax_q;
      pile_d  = dbl_q | pend_q;
      ovl_d   = force_c;
      valid_d = 1'b1;
      pend_d  = 1'b0;
      hcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      max_q      <= '0;
      tmax_q     <= '0;
      len_q      <= '0;
      hcnt_q     <= '0;
      fell_q     <= 1'b0;
      dbl_q      <= 1'b0;
      pend_q     <= 1'b0;
      peak_amp   <= '0;
      peak_time  <= '0;
      peak_valid <= 1'b0;
      pile_up    <= 1'b0;
      over_len   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + TS_W'(1);
      max_q      <= max_d;
      tmax_q     <= tmax_d;
      len_q      <= len_d;
      hcnt_q     <= hcnt_d;
      fell_q     <= fell_d;
      dbl_q      <= dbl_d;
      pend_q     <= pend_d;
      peak_amp   <= amp_d;
      peak_time  <= time_d;
      peak_valid <= valid_d;
      pile_up    <= pile_d;
      over_len   <= ovl_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_peak_finder.sv
// Scoreboard bench for peak_finder: a pulse-level reference model queues the
// expected per-cycle response; a monitor pops and compares after each edge.
module tb_peak_finder;
  localparam int DW = 20;
  localparam int TW = 16;
  localparam int HY = 8;
  localparam int ML = 64;
  localparam int HO = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] input_data = '0;
  logic signed [DW-1:0] thr = DW'(100);
  logic signed [DW-1:0] peak_amp;
  logic [TW-1:0]        peak_time;
  logic                 peak_valid, pile_up, over_len, busy;

  always #5 clk = ~clk;

  peak_finder #(.DATA_W(DW), .TS_W(TW), .HYST(HY), .MAX_LEN(ML), .HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .thr(thr),
    .peak_amp(peak_amp), .peak_time(peak_time), .peak_valid(peak_valid),
    .pile_up(pile_up), .over_len(over_len), .busy(busy)
  );

  typedef struct {
    bit valid;
    bit busy;
    int amp;
    int tim;
    bit pile;
    bit ovl;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   thr_v = 100;

  // Reference model: a pulse is the list of its above-threshold samples
  int   m_ts = 0;
  bit   m_in = 0, m_hold = 0, m_pend = 0;
  int   m_dead = 0;
  int   pv[$];
  int   pt[$];

  // Values seen on the DUT's latest strobe
  int   last_amp = 0, last_time = 0, cyc = 0;
  bit   last_pile = 0, last_ovl = 0;
  int   ovl_cyc[$];

  int p_single[8] = '{0, 50, 200, 500, 500, 300, 80, 0};
  int p_double[6] = '{200, 600, 400, 580, 650, 90};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  // Event of the stored pulse: max, first time of max, and whether a rise
  // followed a drop of more than HY below the running max
  function automatic exp_t emit_event(bit ov);
    exp_t e;
    int   m, t;
    bit   fell, dbl;
    m = pv[0]; t = pt[0]; fell = 0; dbl = 0;
    for (int i = 1; i < pv.size(); i++) begin
      if (pv[i] < m - HY) fell = 1;
      else if (pv[i] > m) begin
        dbl = dbl | fell;
        m = pv[i];
        t = pt[i];
      end
    end
    e.valid = 1; e.busy = 1; e.amp = m; e.tim = t; e.pile = dbl | m_pend; e.ovl = ov;
    m_pend = 0; m_in = 0; m_hold = 1; m_dead = HO;
    return e;
  endfunction

  task automatic start_pulse(input int x);
    pv.delete(); pt.delete();
    pv.push_back(x); pt.push_back(m_ts);
    m_in = 1; m_hold = 0;
  endtask

  task automatic step(input int x);
    exp_t e;
    bit   above;
    @(negedge clk);
    reset = 1'b0;
    input_data = DW'(x);
    thr = DW'(thr_v);
    e.valid = 0; e.busy = 0; e.amp = 0; e.tim = 0; e.pile = 0; e.ovl = 0;
    above = x > thr_v;
    if (m_in) begin
      if (!above) e = emit_event(0);
      else if (pv.size() == ML - 1) e = emit_event(1);
      else begin
        pv.push_back(x); pt.push_back(m_ts);
      end
    end else if (m_hold) begin
      if (m_dead > 0) begin
        m_dead--;
        if (above) m_pend = 1;
      end else if (above) start_pulse(x);
      else begin
        m_hold = 0; m_pend = 0;
      end
    end else if (above) start_pulse(x);
    e.busy = m_in | m_hold;
    exp_q.push_back(e);
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1'b1;
      input_data = '0;
    end
    m_in = 0; m_hold = 0; m_pend = 0; m_dead = 0; m_ts = 0;
    pv.delete(); pt.delete();
    @(posedge clk);
    #2;
    chk("rst_valid", 32'(peak_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_amp", 32'(peak_amp), 32'(0));
    chk("rst_time", 32'(peak_time), 32'(0));
    chk("rst_pile", 32'(pile_up), 32'(0));
    chk("rst_ovl", 32'(over_len), 32'(0));
  endtask

  // Monitor: one expected record per applied sample
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (peak_valid === 1'b1) begin
        last_amp = int'(peak_amp);
        last_time = int'(peak_time);
        last_pile = pile_up;
        last_ovl = over_len;
        if (over_len === 1'b1) ovl_cyc.push_back(cyc);
      end
      if (exp_q.size() == 0) begin
        chk("no_strobe", 32'(peak_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("valid", 32'(peak_valid), 32'(e.valid));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("pile_up", 32'(pile_up), 32'(e.pile));
        chk("over_len", 32'(over_len), 32'(e.ovl));
        if (e.valid) begin
          chk("peak_amp", 32'(peak_amp), 32'(e.amp));
          chk("peak_time", 32'(peak_time), 32'(e.tim));
        end
      end
    end
  end

  initial begin
    int x, r, gap;
    do_reset(3);

    thr_v = 100;
    idle(10);
    foreach (p_single[i]) step(p_single[i]);
    idle(30);
    chk("single_amp", 32'(last_amp), 32'(500));
    chk("single_time", 32'(last_time), 32'(13));
    chk("single_pile", 32'(last_pile), 32'(0));
    chk("single_ovl", 32'(last_ovl), 32'(0));

    foreach (p_double[i]) step(p_double[i]);
    idle(30);
    chk("double_amp", 32'(last_amp), 32'(650));
    chk("double_pile", 32'(last_pile), 32'(1));

    step(300); step(400); step(0);
    idle(3);
    repeat (20) step(300);
    idle(30);
    chk("retrig_pile", 32'(last_pile), 32'(1));
    step(200); step(300); step(0);
    idle(30);
    chk("isolated_pile", 32'(last_pile), 32'(0));
    chk("isolated_amp", 32'(last_amp), 32'(300));

    ovl_cyc.delete();
    repeat (200) step(1000);
    idle(40);
    chk("stuck_ovl_count", 32'(ovl_cyc.size()), 32'(2));
    gap = (ovl_cyc.size() >= 2) ? ovl_cyc[1] - ovl_cyc[0] : -1;
    chk("stuck_period", 32'(gap), 32'(ML + HO));

    x = 0;
    repeat (1500) begin
      if ($urandom_range(0, 49) == 0) thr_v = int'($urandom_range(0, 400));
      r = int'($urandom_range(0, 9));
      if (r < 3) x = -int'($urandom_range(0, 500));
      else if (r < 6) x = x + int'($urandom_range(0, 40)) - 20;
      else x = int'($urandom_range(0, 1200));
      step(x);
    end
    thr_v = 100;
    repeat (3) begin
      repeat (100) step(500 + int'($urandom_range(0, 700)));
      idle(20);
    end

    idle(20);
    step(300); step(400);
    do_reset(2);
    idle(3);
    step(250); step(0);
    idle(25);
    chk("post_reset_amp", 32'(last_amp), 32'(250));
    chk("post_reset_time", 32'(last_time), 32'(3));

    while (m_ts != 65533) step(0);
    step(200); step(300); step(900); step(500); step(0);
    idle(25);
    chk("wrap_time", 32'(last_time), 32'(65535));
    chk("wrap_amp", 32'(last_amp), 32'(900));

    repeat (2) @(posedge clk);
    #3;
    chk("drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
